// File: rtl/pm_share_ctrl.sv
// Shares one combinational W x W multiplier between two requesters.
// Round-robin request arbitration, multicycle operand hold, registered product response.
module pm_share_ctrl #(
  parameter int W          = 8,
  parameter int MUL_CYCLES = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  input  logic [W-1:0]   req0_x,
  input  logic [W-1:0]   req0_y,
  output logic           req0_ready,
  input  logic           req1_valid,
  input  logic [W-1:0]   req1_x,
  input  logic [W-1:0]   req1_y,
  output logic           req1_ready,
  output logic           rsp0_valid,
  input  logic           rsp0_ready,
  output logic           rsp1_valid,
  input  logic           rsp1_ready,
  output logic [2*W-1:0] rsp_z,
  output logic [W-1:0]   mul_x,
  output logic [W-1:0]   mul_y,
  input  logic [2*W-1:0] mul_z,
  output logic           busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, RESP = 2'd2} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MUL_CYCLES - 1);

  state_t         state_q;
  logic [W-1:0]   op_x_q, op_y_q;
  logic [2*W-1:0] res_q;
  logic           owner_q, prio_q, busy_q;
  logic [3:0]     cnt_q;
  logic           rsp0_vld_q, rsp1_vld_q;

  logic grant, accept, rsp_hs;

  // Contention goes to prio; otherwise the lone valid requester wins.
  always_comb begin
    grant      = (req0_valid & req1_valid) ? prio_q : req1_valid;
    accept     = (state_q == IDLE) & (req0_valid | req1_valid);
    req0_ready = accept & ~grant;
    req1_ready = accept & grant;
    rsp_hs     = owner_q ? (rsp1_vld_q & rsp1_ready) : (rsp0_vld_q & rsp0_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_x_q     <= '0;
      op_y_q     <= '0;
      res_q      <= '0;
      owner_q    <= 1'b0;
      prio_q     <= 1'b0;
      cnt_q      <= 4'd0;
      rsp0_vld_q <= 1'b0;
      rsp1_vld_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          op_x_q  <= grant ? req1_x : req0_x;
          op_y_q  <= grant ? req1_y : req0_y;
          owner_q <= grant;
          prio_q  <= ~grant;
          cnt_q   <= CNT_INIT;
          busy_q  <= 1'b1;
          state_q <= MUL;
        end
        // mul_z is only sampled once the settle count runs out.
        MUL: if (cnt_q != 4'd0) begin
          cnt_q <= cnt_q - 4'd1;
        end else begin
          res_q      <= mul_z;
          rsp0_vld_q <= ~owner_q;
          rsp1_vld_q <= owner_q;
          state_q    <= RESP;
        end
        RESP: if (rsp_hs) begin
          rsp0_vld_q <= 1'b0;
          rsp1_vld_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mul_x      = op_x_q;
  assign mul_y      = op_y_q;
  assign rsp_z      = res_q;
  assign rsp0_valid = rsp0_vld_q;
  assign rsp1_valid = rsp1_vld_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_pm_share_ctrl.sv
// Bench for pm_share_ctrl: instance A (MUL_CYCLES=1) with an ideal multiplier,
// instance B (MUL_CYCLES=4) whose multiplier output can be corrupted while settling.
module tb_pm_share_ctrl;
  localparam int MC_A = 1;

  typedef struct packed { logic [7:0] x; logic [7:0] y; } op_t;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic a_req0_valid = 0, a_req1_valid = 0, a_rsp0_ready = 0, a_rsp1_ready = 0;
  logic [7:0] a_req0_x = 0, a_req0_y = 0, a_req1_x = 0, a_req1_y = 0;
  logic a_req0_ready, a_req1_ready, a_rsp0_valid, a_rsp1_valid, a_busy;
  logic [15:0] a_rsp_z, a_mul_z;
  logic [7:0] a_mul_x, a_mul_y;

  logic b_req0_valid = 0, b_req1_valid = 0, b_rsp0_ready = 0, b_rsp1_ready = 0;
  logic [7:0] b_req0_x = 0, b_req0_y = 0, b_req1_x = 0, b_req1_y = 0;
  logic b_req0_ready, b_req1_ready, b_rsp0_valid, b_rsp1_valid, b_busy;
  logic [15:0] b_rsp_z, b_mul_z, b_junk = 0;
  logic [7:0] b_mul_x, b_mul_y;
  logic b_garbage = 0;

  assign a_mul_z = 16'(a_mul_x) * 16'(a_mul_y);
  assign b_mul_z = b_garbage ? b_junk : 16'(b_mul_x) * 16'(b_mul_y);

  pm_share_ctrl #(.W(8), .MUL_CYCLES(MC_A)) u_a (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(a_req0_valid), .req0_x(a_req0_x), .req0_y(a_req0_y), .req0_ready(a_req0_ready),
    .req1_valid(a_req1_valid), .req1_x(a_req1_x), .req1_y(a_req1_y), .req1_ready(a_req1_ready),
    .rsp0_valid(a_rsp0_valid), .rsp0_ready(a_rsp0_ready),
    .rsp1_valid(a_rsp1_valid), .rsp1_ready(a_rsp1_ready),
    .rsp_z(a_rsp_z), .mul_x(a_mul_x), .mul_y(a_mul_y), .mul_z(a_mul_z), .busy(a_busy));

  pm_share_ctrl #(.W(8), .MUL_CYCLES(4)) u_b (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(b_req0_valid), .req0_x(b_req0_x), .req0_y(b_req0_y), .req0_ready(b_req0_ready),
    .req1_valid(b_req1_valid), .req1_x(b_req1_x), .req1_y(b_req1_y), .req1_ready(b_req1_ready),
    .rsp0_valid(b_rsp0_valid), .rsp0_ready(b_rsp0_ready),
    .rsp1_valid(b_rsp1_valid), .rsp1_ready(b_rsp1_ready),
    .rsp_z(b_rsp_z), .mul_x(b_mul_x), .mul_y(b_mul_y), .mul_z(b_mul_z), .busy(b_busy));

  int n_checks = 0, n_fail = 0;
  bit mprio = 0;
  op_t q0[$], q1[$];
  bit order[$];
  int acc_cyc[$];
  logic [15:0] got_z[$];

  // Model of instance A: serves the queued requests, predicting grant, latency and product.
  task automatic serve_a(input int max_cyc, input bit rnd_bp);
    int c = 0, acc_c = 0;
    bit infl = 0, own = 0, e0, e1, g, ev, done;
    logic [15:0] ez = 0;
    order.delete(); acc_cyc.delete(); got_z.delete();
    while ((q0.size() > 0 || q1.size() > 0 || infl) && c < max_cyc) begin
      @(negedge clk);
      a_req0_valid = q0.size() > 0;
      if (q0.size() > 0) begin a_req0_x = q0[0].x; a_req0_y = q0[0].y; end
      a_req1_valid = q1.size() > 0;
      if (q1.size() > 0) begin a_req1_x = q1[0].x; a_req1_y = q1[0].y; end
      a_rsp0_ready = rnd_bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      a_rsp1_ready = rnd_bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      e0 = 0; e1 = 0;
      if (!infl && (a_req0_valid || a_req1_valid)) begin
        g = (a_req0_valid && a_req1_valid) ? mprio : a_req1_valid;
        e0 = !g; e1 = g;
      end
      n_checks++;
      if ({a_req0_ready, a_req1_ready} !== {e0, e1}) begin
        n_fail++; $display("FAIL serve_ready c=%0d: got %b%b want %b%b", c, a_req0_ready, a_req1_ready, e0, e1);
      end
      n_checks++;
      if (a_busy !== infl) begin n_fail++; $display("FAIL serve_busy c=%0d: got %b want %b", c, a_busy, infl); end
      ev = infl && (c >= acc_c + MC_A + 1);
      n_checks++;
      if (a_rsp0_valid !== (ev && !own) || a_rsp1_valid !== (ev && own)) begin
        n_fail++; $display("FAIL serve_rsp_valid c=%0d: got %b%b want %b%b", c, a_rsp0_valid, a_rsp1_valid, ev && !own, ev && own);
      end
      if (ev) begin
        n_checks++;
        if (a_rsp_z !== ez) begin n_fail++; $display("FAIL serve_rsp_z c=%0d: got %h want %h", c, a_rsp_z, ez); end
      end
      done = ev && (own ? a_rsp1_ready : a_rsp0_ready);
      @(posedge clk);
      if (done) begin infl = 0; got_z.push_back(a_rsp_z); end
      if (e0 || e1) begin
        infl = 1; own = e1; acc_c = c; mprio = !e1;
        ez = e1 ? 16'(q1[0].x) * 16'(q1[0].y) : 16'(q0[0].x) * 16'(q0[0].y);
        order.push_back(e1); acc_cyc.push_back(c);
        if (e1) void'(q1.pop_front()); else void'(q0.pop_front());
      end
      c++;
    end
    n_checks++;
    if (c >= max_cyc) begin n_fail++; $display("FAIL serve_timeout: got %0d cycles want < %0d", c, max_cyc); end
    @(negedge clk);
    a_req0_valid = 0; a_req1_valid = 0; a_rsp0_ready = 0; a_rsp1_ready = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 0;
    @(negedge clk); @(negedge clk); rst_n = 1;
    mprio = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({a_req0_ready, a_req1_ready, a_rsp0_valid, a_rsp1_valid, a_busy} !== 5'b0 ||
        {b_req0_ready, b_req1_ready, b_rsp0_valid, b_rsp1_valid, b_busy} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got a=%b%b%b%b%b b=%b%b%b%b%b want all 0", a_req0_ready, a_req1_ready,
        a_rsp0_valid, a_rsp1_valid, a_busy, b_req0_ready, b_req1_ready, b_rsp0_valid, b_rsp1_valid, b_busy);
    end
    n_checks++;
    if ({a_rsp_z, a_mul_x, a_mul_y, b_rsp_z, b_mul_x, b_mul_y} !== 64'h0) begin
      n_fail++; $display("FAIL reset_data: got a_z=%h a_x=%h a_y=%h b_z=%h b_x=%h b_y=%h want 0",
        a_rsp_z, a_mul_x, a_mul_y, b_rsp_z, b_mul_x, b_mul_y);
    end
    rst_n = 1; mprio = 0;
  endtask

  task automatic test_single();
    @(negedge clk);
    a_req0_valid = 1; a_req0_x = 8'hAA; a_req0_y = 8'h8A; a_rsp0_ready = 0; a_rsp1_ready = 1;
    #1;
    n_checks++;
    if ({a_req0_ready, a_req1_ready} !== 2'b10) begin n_fail++; $display("FAIL single_ready: got %b%b want 10", a_req0_ready, a_req1_ready); end
    @(posedge clk); #1 a_req0_valid = 0;
    @(negedge clk);
    n_checks++;
    if (a_busy !== 1'b1 || a_mul_x !== 8'hAA || a_mul_y !== 8'h8A || a_rsp0_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_mul: got busy=%b x=%h y=%h v=%b want 1 aa 8a 0", a_busy, a_mul_x, a_mul_y, a_rsp0_valid);
    end
    @(negedge clk);
    n_checks++;
    if (a_rsp0_valid !== 1'b1 || a_rsp1_valid !== 1'b0 || a_rsp_z !== 16'h5BA4) begin
      n_fail++; $display("FAIL single_rsp: got v0=%b v1=%b z=%h want 1 0 5ba4", a_rsp0_valid, a_rsp1_valid, a_rsp_z);
    end
    a_rsp0_ready = 1;
    @(negedge clk);
    n_checks++;
    if (a_rsp0_valid !== 1'b0 || a_busy !== 1'b0) begin
      n_fail++; $display("FAIL single_done: got v0=%b busy=%b want 0 0", a_rsp0_valid, a_busy);
    end
    a_rsp0_ready = 0; a_rsp1_ready = 0;
    mprio = 1;
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    a_req0_valid = 1; a_req0_x = 8'hAA; a_req0_y = 8'h8A; a_rsp0_ready = 0; a_rsp1_ready = 1;
    @(posedge clk); #1 a_req0_valid = 0;
    a_req1_valid = 1; a_req1_x = 8'h13; a_req1_y = 8'hE7;
    @(negedge clk); @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (a_rsp0_valid !== 1'b1 || a_rsp1_valid !== 1'b0 || a_rsp_z !== 16'h5BA4 ||
          a_req0_ready !== 1'b0 || a_req1_ready !== 1'b0 || a_busy !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got v0=%b v1=%b z=%h r0=%b r1=%b busy=%b want 1 0 5ba4 0 0 1",
          i, a_rsp0_valid, a_rsp1_valid, a_rsp_z, a_req0_ready, a_req1_ready, a_busy);
      end
      if (i < 4) @(negedge clk);
    end
    a_rsp0_ready = 1;
    mprio = 1;
    q1.push_back('{x: 8'h13, y: 8'hE7});
    serve_a(20, 0);
    n_checks++;
    if (got_z.size() != 1 || got_z[0] !== 16'h1125) begin
      n_fail++; $display("FAIL bp_next: got n=%0d z=%h want 1 1125", got_z.size(), got_z.size() ? got_z[0] : 16'hx);
    end
  endtask

  task automatic test_contention();
    do_reset();
    q0.push_back('{x: 8'hAA, y: 8'h8A});
    q1.push_back('{x: 8'hAA, y: 8'h86});
    serve_a(30, 0);
    n_checks++;
    if (order.size() != 2 || got_z.size() != 2) begin
      n_fail++; $display("FAIL cont_count: got %0d/%0d want 2/2", order.size(), got_z.size());
    end else begin
      n_checks++;
      if (order[0] !== 1'b0 || order[1] !== 1'b1 || got_z[0] !== 16'h5BA4 || got_z[1] !== 16'h58FC) begin
        n_fail++; $display("FAIL cont_order: got %b%b z=%h,%h want 01 5ba4,58fc", order[0], order[1], got_z[0], got_z[1]);
      end
      n_checks++;
      if (acc_cyc[1] - acc_cyc[0] != 3) begin
        n_fail++; $display("FAIL cont_interval: got %0d want 3", acc_cyc[1] - acc_cyc[0]);
      end
    end
  endtask

  task automatic test_fairness();
    bit exp_o[4] = '{0, 1, 0, 1};
    for (int i = 0; i < 2; i++) begin
      q0.push_back('{x: 8'($urandom), y: 8'($urandom)});
      q1.push_back('{x: 8'($urandom), y: 8'($urandom)});
    end
    serve_a(60, 0);
    n_checks++;
    if (order.size() != 4) begin
      n_fail++; $display("FAIL fair_count: got %0d want 4", order.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (order[i] !== exp_o[i]) begin n_fail++; $display("FAIL fair_order[%0d]: got %b want %b", i, order[i], exp_o[i]); end
      end
    end
  endtask

  task automatic test_random();
    int n0, n1;
    for (int r = 0; r < 3; r++) begin
      n0 = $urandom_range(1, 4); n1 = $urandom_range(1, 4);
      for (int i = 0; i < n0; i++) q0.push_back('{x: 8'($urandom), y: 8'($urandom)});
      for (int i = 0; i < n1; i++) q1.push_back('{x: 8'($urandom), y: 8'($urandom)});
      serve_a(300, 1);
      n_checks++;
      if (got_z.size() != n0 + n1) begin
        n_fail++; $display("FAIL rand_count[%0d]: got %0d want %0d", r, got_z.size(), n0 + n1);
      end
    end
  endtask

  task automatic test_mul4();
    @(negedge clk);
    b_req1_valid = 1; b_req1_x = 8'h4A; b_req1_y = 8'hA6; b_rsp1_ready = 0; b_rsp0_ready = 1;
    #1;
    n_checks++;
    if ({b_req0_ready, b_req1_ready} !== 2'b01) begin n_fail++; $display("FAIL m4_ready: got %b%b want 01", b_req0_ready, b_req1_ready); end
    @(posedge clk); #1 b_req1_valid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      b_garbage = 1; b_junk = 16'($urandom);
      n_checks++;
      if (b_busy !== 1'b1 || b_rsp1_valid !== 1'b0 || b_mul_x !== 8'h4A) begin
        n_fail++; $display("FAIL m4_settle[%0d]: got busy=%b v1=%b x=%h want 1 0 4a", i, b_busy, b_rsp1_valid, b_mul_x);
      end
    end
    @(negedge clk);
    b_garbage = 0;
    n_checks++;
    if (b_rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL m4_early: got v1=%b want 0", b_rsp1_valid); end
    @(negedge clk);
    n_checks++;
    if (b_rsp1_valid !== 1'b1 || b_rsp0_valid !== 1'b0 || b_rsp_z !== 16'h2FFC) begin
      n_fail++; $display("FAIL m4_rsp: got v1=%b v0=%b z=%h want 1 0 2ffc", b_rsp1_valid, b_rsp0_valid, b_rsp_z);
    end
    b_garbage = 1; b_junk = 16'($urandom);
    @(negedge clk);
    n_checks++;
    if (b_rsp1_valid !== 1'b1 || b_rsp_z !== 16'h2FFC) begin
      n_fail++; $display("FAIL m4_stable: got v1=%b z=%h want 1 2ffc", b_rsp1_valid, b_rsp_z);
    end
    b_rsp1_ready = 1;
    @(negedge clk);
    n_checks++;
    if (b_rsp1_valid !== 1'b0 || b_busy !== 1'b0) begin
      n_fail++; $display("FAIL m4_done: got v1=%b busy=%b want 0 0", b_rsp1_valid, b_busy);
    end
    b_garbage = 0; b_rsp1_ready = 0; b_rsp0_ready = 0;
  endtask

  task automatic test_reset_mid_mul();
    @(negedge clk);
    b_req0_valid = 1; b_req0_x = 8'h5C; b_req0_y = 8'h33; b_rsp0_ready = 1; b_rsp1_ready = 1;
    @(posedge clk); #1 b_req0_valid = 0;
    @(negedge clk);
    n_checks++;
    if (b_busy !== 1'b1 || b_mul_x !== 8'h5C) begin n_fail++; $display("FAIL rmm_pre: got busy=%b x=%h want 1 5c", b_busy, b_mul_x); end
    rst_n = 0;
    #1;
    n_checks++;
    if ({b_busy, b_rsp0_valid, b_rsp1_valid, b_req0_ready, b_req1_ready} !== 5'b0 ||
        {b_mul_x, b_mul_y, b_rsp_z} !== 32'h0) begin
      n_fail++; $display("FAIL rmm_async: got busy=%b v=%b%b x=%h y=%h z=%h want all 0",
        b_busy, b_rsp0_valid, b_rsp1_valid, b_mul_x, b_mul_y, b_rsp_z);
    end
    @(negedge clk); rst_n = 1; mprio = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (b_rsp0_valid !== 1'b0 || b_rsp1_valid !== 1'b0 || b_busy !== 1'b0) begin
        n_fail++; $display("FAIL rmm_silent[%0d]: got v=%b%b busy=%b want 00 0", i, b_rsp0_valid, b_rsp1_valid, b_busy);
      end
    end
    b_req0_valid = 1; b_req1_valid = 1; b_req1_x = 8'h01; b_req1_y = 8'h02;
    #1;
    n_checks++;
    if ({b_req0_ready, b_req1_ready} !== 2'b10) begin n_fail++; $display("FAIL rmm_grant: got %b%b want 10", b_req0_ready, b_req1_ready); end
    b_req0_valid = 0; b_req1_valid = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_contention();
    test_fairness();
    test_random();
    test_mul4();
    test_reset_mid_mul();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
